button_debouncer: RTL
=====================

# button_debouncer

Conditions one raw, bouncing push-button input into clean single-clock-cycle press events and a stable debounced level. It sits directly upstream of the LED sequencer and drives that stage's `button` input with `press_pulse`. Each physical press therefore starts or restarts the sequence exactly once. An optional long-press detector reports a press held beyond a second threshold.

## Interface
- `DEBOUNCE_CYCLES`, default 32'd1000000: cycles the synchronized input must stay stable before a level change is accepted (10 ms at 100 MHz). Must be ≥ 1.
- `LONG_CYCLES`, default 32'd100000000: cycles in HELD before `long_pulse` fires (1 s at 100 MHz). Must be ≥ 1.
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in 1: raw asynchronous button input, active-high.
- `press_pulse` out 1: one-cycle pulse per accepted press. Reset 0.
- `level` out 1: debounced button level. Reset 0.
- `long_pulse` out 1: one-cycle pulse per press held ≥ `LONG_CYCLES`. Reset 0.

## Operation
- Two-flop synchronizer on `btn_in`; both flops reset to 0. The FSM sees only the second flop output `s`.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Reset state is IDLE. One 32-bit stability counter `cnt`, reset to 0.
  - IDLE: `s`=1 → PRESS_WAIT, `cnt`<=0.
  - PRESS_WAIT: `s`=0 → IDLE (bounce, no output). Else if `cnt`==DEBOUNCE_CYCLES-1 → HELD with `press_pulse`<=1 and `level`<=1. Else `cnt`++.
  - HELD: `s`=0 → RELEASE_WAIT, `cnt`<=0.
  - RELEASE_WAIT: `s`=1 → HELD (bounce, `level` stays 1, no new pulse). Else if `cnt`==DEBOUNCE_CYCLES-1 → IDLE with `level`<=0. Else `cnt`++.
- `press_pulse` and `long_pulse` are registered. Each is high for exactly one cycle, then cleared the next cycle.
- The counter compares with equality only and never wraps. It is cleared on every state entry.
- Release produces no pulse; only `level` falls.
- Reset mid-operation: all state, counters and outputs clear at the next edge with `rst`=1, including a pulse in flight. A button still held after reset is treated as a new press and must pass full debounce, which produces one `press_pulse`.

## Timing
- Press latency: `btn_in` rises before edge 1 → `s`=1 after edge 2 → PRESS_WAIT after edge 3 → `press_pulse` high in the cycle after edge DEBOUNCE_CYCLES+3.
- Release latency: `level` falls in the cycle after edge DEBOUNCE_CYCLES+3, counted from the first edge sampling `btn_in`=0.
- Any glitch shorter than DEBOUNCE_CYCLES cycles after synchronization produces no output change.
- Minimum spacing between two `press_pulse`s is 2·DEBOUNCE_CYCLES+2 cycles.

## Configuration
- `BUTTON_LONG_PRESS_EN` defined:
  - A second 32-bit counter runs only in HELD. It clears on entry to HELD and holds through RELEASE_WAIT bounces that return to HELD.
  - When it reaches LONG_CYCLES-1, `long_pulse` fires once. Further counting stops until the next press (next entry from PRESS_WAIT).
- Undefined: the long-press counter and logic are not compiled. `long_pulse` stays present and is tied to 0.

## Structure
- Shared package/header `lab_pkg` holds:
  - FSM state encodings (2-bit: IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3).
  - Default cycle constants for the 100 MHz board clock, shared with the LED sequencer's delay.
- One sub-module, `sync_2ff` (clk, rst, d, q), implements the synchronizer. It is reusable for other board inputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=10.
- Clean press: `btn_in` 0→1 before edge 1 and held → `press_pulse`=1 only in the cycle after edge 7; `level`=1 from then on.
- Bounce on press: `btn_in` 1 for 2 cycles, 0 for 1, then held 1 → no pulse during the bounce; exactly one `press_pulse` 7 edges after the final rise.
- Bounce on release: while HELD, `btn_in` 0 for 2 cycles then 1 → `level` stays 1 with no `press_pulse`. Then a clean release → `level`=0 7 edges after the fall.
- Long press (macro defined): hold 30 cycles → exactly one `press_pulse` and one `long_pulse`, 10 cycles apart. With the macro undefined → `long_pulse` never asserts.
- Reset mid-press: assert `rst` for 1 cycle while in PRESS_WAIT with `btn_in` held → all outputs 0 after that edge; one `press_pulse` 7 edges after `rst` deasserts.
- Short glitch: a 3-cycle `btn_in` pulse from IDLE → `press_pulse` and `level` stay 0 throughout.

Source files
------------

// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared board constants and debouncer FSM state encoding
package lab_pkg;

  // Defaults for the 100 MHz board clock; the LED sequencer delay uses the same values.
  localparam logic [31:0] DEFAULT_DEBOUNCE_CYCLES = 32'd1000000;
  localparam logic [31:0] DEFAULT_LONG_CYCLES     = 32'd100000000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous single-bit board inputs
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button debouncer with press pulse, level and optional long press (BUTTON_LONG_PRESS_EN)
module button_debouncer
  import lab_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [31:0] LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic level,
  output logic long_pulse
);

  logic        s;
  btn_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        press_d, level_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      press_pulse <= 1'b0;
      level       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_pulse <= press_d;
      level       <= level_d;
    end
  end

  // Counter is cleared on every state change and compared by equality only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    level_d = level;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = 32'd0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = 32'd0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 32'd1) begin
          state_d = ST_HELD;
          cnt_d   = 32'd0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = 32'd0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_HELD;
          cnt_d   = 32'd0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 32'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 32'd0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

`ifdef BUTTON_LONG_PRESS_EN
  logic [31:0] lcnt_q, lcnt_d;
  logic        ldone_q, ldone_d;
  logic        long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q     <= 32'd0;
      ldone_q    <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      lcnt_q     <= lcnt_d;
      ldone_q    <= ldone_d;
      long_pulse <= long_d;
    end
  end

  // Only a fresh press re-arms the detector; release bounces back into HELD keep the count.
  always_comb begin
    lcnt_d  = lcnt_q;
    ldone_d = ldone_q;
    long_d  = 1'b0;
    if (state_q == ST_PRESS_WAIT && state_d == ST_HELD) begin
      lcnt_d  = 32'd0;
      ldone_d = 1'b0;
    end else if (state_q == ST_HELD && !ldone_q) begin
      if (lcnt_q == LONG_CYCLES - 32'd1) begin
        long_d  = 1'b1;
        ldone_d = 1'b1;
      end else begin
        lcnt_d = lcnt_q + 32'd1;
      end
    end
  end
`else
  // LONG_CYCLES stays referenced so both builds share one parameter interface.
  assign long_pulse = 1'b0 && (LONG_CYCLES != 32'd0);
`endif

endmodule
